// File: rtl/cmos_frame_wr_ctrl.sv
// Camera frame write controller: moves pixel FIFO data into one of two frame
// banks as fixed-size write bursts, with double-buffer bank swapping.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | capture disabled
// S_WAIT_SOF  | waiting for start of frame (vs_fall)
// S_WAIT_DATA | waiting for enough FIFO words for the next burst
// S_REQ       | burst requested, address/length held until wr_ack
// S_BURST     | burst granted, waiting for wr_done
// S_DONE      | frame complete, publish bank and decide on swap
module cmos_frame_wr_ctrl #(
    parameter int unsigned       BURST_LEN   = 64,
    parameter int unsigned       FRAME_WORDS = 307200,
    parameter int unsigned       ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] BANK1_BASE  = 24'h080000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              vs_fall,
    input  logic              vs_rise,
    input  logic [9:0]        fifo_count,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_len,
    input  logic              wr_ack,
    input  logic              wr_done,
    input  logic              rd_bank,
    output logic              wr_bank,
    output logic              ready_bank,
    output logic              frame_done,
    output logic              frame_drop,
    output logic              fifo_clr,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_SOF, S_WAIT_DATA, S_REQ, S_BURST, S_DONE
    } state_t;

    localparam logic [18:0] FRAME19 = 19'(FRAME_WORDS);
    localparam logic [18:0] BURST19 = 19'(BURST_LEN);
    localparam logic [7:0]  BURST8  = 8'(BURST_LEN);

    state_t            state, state_next;
    logic [18:0]       offset, offset_next;
    logic [18:0]       remaining, remaining_next;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        len_next;
    logic              bank_next, ready_next;
    logic              pend_rise, pend_rise_next;
    logic              pend_fall, pend_fall_next;
    logic              final_q, final_next;
    logic              drop_next, clr_next;

    logic [7:0]        full_len, part_len;
    logic [ADDR_W-1:0] addr_calc;
    logic [18:0]       off_after, rem_after;
    logic              rise_any, fall_any;

    // Burst sizing and address arithmetic shared by the next-state logic.
    always_comb begin
        full_len  = (remaining < BURST19) ? remaining[7:0] : BURST8;
        part_len  = ({9'd0, fifo_count} < {11'd0, full_len}) ? fifo_count[7:0] : full_len;
        addr_calc = (wr_bank ? BANK1_BASE : '0) + ADDR_W'(offset);
        off_after = offset + {11'd0, wr_len};
        rem_after = remaining - {11'd0, wr_len};
        rise_any  = vs_rise | pend_rise;
        fall_any  = vs_fall | pend_fall;
    end

    // Next-state and datapath decisions.
    always_comb begin
        state_next     = state;
        offset_next    = offset;
        remaining_next = remaining;
        addr_next      = wr_addr;
        len_next       = wr_len;
        bank_next      = wr_bank;
        ready_next     = ready_bank;
        pend_rise_next = pend_rise;
        pend_fall_next = pend_fall;
        final_next     = final_q;
        drop_next      = 1'b0;
        clr_next       = 1'b0;
        case (state)
            S_IDLE: begin
                pend_rise_next = 1'b0;
                pend_fall_next = 1'b0;
                final_next     = 1'b0;
                if (enable) state_next = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                pend_rise_next = 1'b0;
                if (!enable) begin
                    pend_fall_next = 1'b0;
                    state_next     = S_IDLE;
                end else if (fall_any) begin
                    clr_next       = 1'b1;
                    offset_next    = '0;
                    remaining_next = FRAME19;
                    pend_fall_next = 1'b0;
                    final_next     = 1'b0;
                    state_next     = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (!enable) begin
                    pend_rise_next = 1'b0;
                    pend_fall_next = 1'b0;
                    state_next     = S_IDLE;
                end else if (fall_any) begin
                    // start of a new frame before the old one ended: restart in place
                    drop_next      = 1'b1;
                    clr_next       = 1'b1;
                    offset_next    = '0;
                    remaining_next = FRAME19;
                    pend_rise_next = 1'b0;
                    pend_fall_next = 1'b0;
                end else if (rise_any) begin
                    pend_rise_next = 1'b0;
                    if (fifo_count != '0) begin
                        addr_next  = addr_calc;
                        len_next   = part_len;
                        final_next = 1'b1;
                        state_next = S_REQ;
                    end else begin
                        drop_next  = 1'b1;
                        state_next = S_WAIT_SOF;
                    end
                end else if ({9'd0, fifo_count} >= {11'd0, full_len}) begin
                    addr_next  = addr_calc;
                    len_next   = full_len;
                    final_next = 1'b0;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                pend_rise_next = rise_any;
                pend_fall_next = fall_any;
                if (wr_ack) state_next = S_BURST;
            end
            S_BURST: begin
                pend_rise_next = rise_any;
                pend_fall_next = fall_any;
                if (wr_done) begin
                    offset_next    = off_after;
                    remaining_next = rem_after;
                    if (!enable) begin
                        pend_rise_next = 1'b0;
                        pend_fall_next = 1'b0;
                        state_next     = S_IDLE;
                    end else if (rem_after == '0) begin
                        pend_rise_next = 1'b0;
                        state_next     = S_DONE;
                    end else if (final_q) begin
                        drop_next      = 1'b1;
                        pend_rise_next = 1'b0;
                        final_next     = 1'b0;
                        state_next     = S_WAIT_SOF;
                    end else if (fall_any) begin
                        drop_next      = 1'b1;
                        clr_next       = 1'b1;
                        offset_next    = '0;
                        remaining_next = FRAME19;
                        pend_rise_next = 1'b0;
                        pend_fall_next = 1'b0;
                        state_next     = S_WAIT_DATA;
                    end else begin
                        state_next = S_WAIT_DATA;
                    end
                end
            end
            S_DONE: begin
                pend_rise_next = 1'b0;
                pend_fall_next = fall_any;
                final_next     = 1'b0;
                ready_next     = wr_bank;
                // never start writing into the bank the display is reading
                if (~wr_bank != rd_bank) bank_next = ~wr_bank;
                else                     drop_next = 1'b1;
                state_next = S_WAIT_SOF;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Datapath and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset     <= '0;
            remaining  <= '0;
            wr_addr    <= '0;
            wr_len     <= '0;
            wr_bank    <= 1'b0;
            ready_bank <= 1'b0;
            pend_rise  <= 1'b0;
            pend_fall  <= 1'b0;
            final_q    <= 1'b0;
            frame_drop <= 1'b0;
            fifo_clr   <= 1'b0;
        end else begin
            offset     <= offset_next;
            remaining  <= remaining_next;
            wr_addr    <= addr_next;
            wr_len     <= len_next;
            wr_bank    <= bank_next;
            ready_bank <= ready_next;
            pend_rise  <= pend_rise_next;
            pend_fall  <= pend_fall_next;
            final_q    <= final_next;
            frame_drop <= drop_next;
            fifo_clr   <= clr_next;
        end
    end

    assign wr_req     = (state == S_REQ);
    assign frame_done = (state == S_DONE);
    assign busy       = (state != S_IDLE) && (state != S_WAIT_SOF);

endmodule

// File: tb/tb_cmos_frame_wr_ctrl.sv
// Bench for cmos_frame_wr_ctrl with a 4-word burst, 10-word frame geometry.
module tb_cmos_frame_wr_ctrl;

    localparam int unsigned BL = 4;
    localparam int unsigned FW = 10;
    localparam int unsigned AW = 24;
    localparam logic [23:0] B1 = 24'h080000;
    localparam int EV_CLR = 0, EV_DONE = 1, EV_DROP = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable, vs_fall, vs_rise_s, vs_rise_a;
    logic [9:0]    fifo_count;
    logic          wr_req, wr_ack, wr_done, rd_bank;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_len;
    logic          wr_bank, ready_bank, frame_done, frame_drop, fifo_clr, busy;

    int checks = 0;
    int failures = 0;

    typedef struct { logic [23:0] addr; logic [7:0] len; } burst_t;
    burst_t exp_burst[$];
    int     exp_evt[$];

    int arb_en = 1;
    int ack_delay = 0;
    logic rise_with_done = 1'b0;

    cmos_frame_wr_ctrl #(.BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW), .BANK1_BASE(B1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .vs_fall(vs_fall),
        .vs_rise(vs_rise_s | vs_rise_a), .fifo_count(fifo_count),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
        .wr_done(wr_done), .rd_bank(rd_bank), .wr_bank(wr_bank),
        .ready_bank(ready_bank), .frame_done(frame_done), .frame_drop(frame_drop),
        .fifo_clr(fifo_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_burst(input logic [23:0] a, input logic [7:0] l);
        burst_t b;
        b.addr = a;
        b.len  = l;
        exp_burst.push_back(b);
    endtask

    task automatic evt_seen(input int kind, input string nm);
        if (exp_evt.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s actual=pulse required=none", nm);
        end else begin
            check(nm, kind, exp_evt[0]);
            void'(exp_evt.pop_front());
        end
    endtask

    // Scoreboard monitor: compares every requested burst and every pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (wr_req) begin
                if (exp_burst.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wr_req addr=%0h len=%0d required=none", wr_addr, wr_len);
                end else begin
                    check("wr_addr", wr_addr, exp_burst[0].addr);
                    check("wr_len", wr_len, exp_burst[0].len);
                    if (wr_ack) void'(exp_burst.pop_front());
                end
            end
            if (fifo_clr)   evt_seen(EV_CLR, "fifo_clr");
            if (frame_done) evt_seen(EV_DONE, "frame_done");
            if (frame_drop) evt_seen(EV_DROP, "frame_drop");
        end
    end

    // Memory arbiter model: grant after ack_delay cycles, complete two cycles later.
    initial begin
        wr_ack = 1'b0;
        wr_done = 1'b0;
        vs_rise_a = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (wr_req && arb_en != 0 && rst_n) begin
                for (int i = 0; i < ack_delay; i++) begin
                    check("stall_req_held", wr_req, 1);
                    @(posedge clk); #1;
                end
                wr_ack = 1'b1;
                @(posedge clk); #1;
                wr_ack = 1'b0;
                @(posedge clk); #1;
                wr_done   = 1'b1;
                vs_rise_a = rise_with_done;
                @(posedge clk); #1;
                wr_done        = 1'b0;
                vs_rise_a      = 1'b0;
                rise_with_done = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic pulse_fall();
        step(); vs_fall = 1'b1;
        step(); vs_fall = 1'b0;
    endtask

    // which: 0 = wr_ack, 1 = wr_done, 2 = wr_req
    task automatic wait_for(input int which, input string nm);
        int n = 0;
        logic s;
        s = (which == 0) ? wr_ack : (which == 1) ? wr_done : wr_req;
        while (!s && n < 200) begin
            step();
            n++;
            s = (which == 0) ? wr_ack : (which == 1) ? wr_done : wr_req;
        end
        check(nm, s, 1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        check(nm, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; vs_fall = 1'b0; vs_rise_s = 1'b0;
        fifo_count = '0; rd_bank = 1'b0;
        step(); step();
        check("rst_wr_req", wr_req, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_bank", wr_bank, 0);
        check("rst_ready_bank", ready_bank, 0);
        check("rst_pulses", {frame_done, frame_drop, fifo_clr}, 0);
        rst_n = 1'b1;
        step();
        enable = 1'b1;
        step(); step();

        // full frame into bank 0, swap to bank 1
        fifo_count = 10'd10; rd_bank = 1'b0;
        push_burst(24'h0, 8'd4); push_burst(24'h4, 8'd4); push_burst(24'h8, 8'd2);
        exp_evt.push_back(EV_CLR); exp_evt.push_back(EV_DONE);
        pulse_fall();
        wait_idle("full0_idle");
        check("full0_wr_bank", wr_bank, 1);
        check("full0_ready_bank", ready_bank, 0);

        // full frame into bank 1, display reads bank 1 so swap back to 0
        rd_bank = 1'b1;
        push_burst(B1 + 24'h0, 8'd4); push_burst(B1 + 24'h4, 8'd4); push_burst(B1 + 24'h8, 8'd2);
        exp_evt.push_back(EV_CLR); exp_evt.push_back(EV_DONE);
        pulse_fall();
        wait_idle("full1_idle");
        check("full1_wr_bank", wr_bank, 0);
        check("full1_ready_bank", ready_bank, 1);

        // bank blocked with arbiter stalling every grant by 5 cycles
        ack_delay = 5;
        push_burst(24'h0, 8'd4); push_burst(24'h4, 8'd4); push_burst(24'h8, 8'd2);
        exp_evt.push_back(EV_CLR); exp_evt.push_back(EV_DONE); exp_evt.push_back(EV_DROP);
        pulse_fall();
        wait_idle("blocked_idle");
        step(); step();
        check("blocked_wr_bank", wr_bank, 0);
        check("blocked_ready_bank", ready_bank, 0);
        ack_delay = 0;

        // short frame: 4 words, then vs_rise with 3 words left in the FIFO
        fifo_count = 10'd4;
        push_burst(24'h0, 8'd4); push_burst(24'h4, 8'd3);
        exp_evt.push_back(EV_CLR); exp_evt.push_back(EV_DROP);
        pulse_fall();
        wait_for(0, "short_ack");
        fifo_count = 10'd0;
        wait_for(1, "short_done");
        step(); step();
        fifo_count = 10'd3; vs_rise_s = 1'b1;
        step(); vs_rise_s = 1'b0;
        wait_idle("short_idle");
        step(); step();
        check("short_wr_bank", wr_bank, 0);

        // vs_rise arrives together with wr_done: partial burst starts after accounting
        fifo_count = 10'd4;
        push_burst(24'h0, 8'd4); push_burst(24'h4, 8'd2);
        exp_evt.push_back(EV_CLR); exp_evt.push_back(EV_DROP);
        pulse_fall();
        wait_for(0, "rise_ack");
        fifo_count = 10'd2;
        rise_with_done = 1'b1;
        wait_idle("rise_idle");
        step(); step();
        check("rise_wr_bank", wr_bank, 0);

        // enable dropped while a burst is in flight
        fifo_count = 10'd10;
        push_burst(24'h0, 8'd4);
        exp_evt.push_back(EV_CLR);
        pulse_fall();
        wait_for(0, "en_ack");
        step(); enable = 1'b0;
        wait_idle("en_idle");
        step();
        check("en_wr_req", wr_req, 0);
        pulse_fall();
        step(); step();
        check("en_idle_ignores_sof", busy, 0);

        // reset pulse while the second burst is being requested
        enable = 1'b1;
        step(); step();
        push_burst(24'h0, 8'd4); push_burst(24'h4, 8'd4);
        exp_evt.push_back(EV_CLR);
        pulse_fall();
        wait_for(0, "rst_ack");
        arb_en = 0;
        wait_for(1, "rst_done");
        step();
        wait_for(2, "rst_req");
        step();
        rst_n = 1'b0;
        #1;
        check("rstmid_wr_req", wr_req, 0);
        check("rstmid_wr_addr", wr_addr, 0);
        check("rstmid_wr_len", wr_len, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_pulses", {frame_done, frame_drop, fifo_clr}, 0);
        check("rstmid_banks", {wr_bank, ready_bank}, 0);
        exp_burst.delete();
        enable = 1'b0;
        step(); step();
        rst_n = 1'b1;
        repeat (5) step();
        check("post_rst_busy", busy, 0);
        check("evt_queue_drained", exp_evt.size(), 0);
        check("burst_queue_drained", exp_burst.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmos_frame_wr_ctrl.md
CMOS_FRAME_WR_CTRL -- requirements
Module: cmos_frame_wr_ctrl

Interface
REQ-001 Parameter BURST_LEN, default 64, SHALL set the maximum words per write burst (range 1..255).
REQ-002 Parameter FRAME_WORDS, default 307200, SHALL set the 16-bit words per frame (640x480 RGB565).
REQ-003 Parameter ADDR_W, default 24, SHALL set the word-address width.
REQ-004 Parameter BANK1_BASE, default 24'h080000, SHALL set the bank-1 base address; bank 0 base SHALL be 0.
REQ-005 Ports, one per line:
- clk  in  1  single clock; all logic on its rising edge; reset is asynchronous and active-low
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  capture enabled (sensor init done, already synchronized)
- vs_fall  in  1  one-cycle pulse at start of frame
- vs_rise  in  1  one-cycle pulse at end of frame
- fifo_count  in  10  words available in the pixel FIFO
- wr_req  out  1  burst write request
- wr_addr  out  ADDR_W  burst start word address
- wr_len  out  8  burst length in words
- wr_ack  in  1  one-cycle grant from the memory arbiter
- wr_done  in  1  one-cycle pulse when the granted burst completes
- rd_bank  in  1  bank currently being read by the display side
- wr_bank  out  1  bank currently being written
- ready_bank  out  1  bank holding the newest complete frame
- frame_done  out  1  one-cycle pulse when a full frame has been written
- frame_drop  out  1  one-cycle pulse when a frame is discarded or overwritten
- fifo_clr  out  1  one-cycle pulse that flushes the pixel FIFO
- busy  out  1  high in every state except IDLE and WAIT_SOF

Function
REQ-006 The FSM SHALL have the states IDLE, WAIT_SOF, WAIT_DATA, REQ, BURST and DONE.
REQ-007 In IDLE, enable=1 SHALL cause a move to WAIT_SOF.
REQ-008 In WAIT_SOF, vs_fall SHALL:
- pulse fifo_clr;
- set the offset to 0 and remaining to FRAME_WORDS;
- move to WAIT_DATA.
REQ-009 In WAIT_DATA, let len = min(BURST_LEN, remaining); fifo_count >= len SHALL move the FSM to REQ with wr_addr = base(wr_bank) + offset and wr_len = len, both registered.
REQ-010 In REQ, wr_req SHALL be 1, and wr_addr and wr_len SHALL stay stable until the wr_ack cycle; on wr_ack the FSM SHALL move to BURST and drop wr_req on the next cycle.
REQ-011 In BURST, wr_done SHALL add wr_len to the offset, subtract wr_len from remaining, and move to DONE if remaining reaches 0, else to WAIT_DATA.
REQ-012 On vs_rise in WAIT_DATA with remaining > 0, the block SHALL:
- if fifo_count > 0, issue one final partial burst of fifo_count words, capped at remaining;
- then pulse frame_drop and return to WAIT_SOF without swapping banks.
REQ-013 A vs_rise or vs_fall arriving in REQ or BURST SHALL be latched and acted on when the burst ends; a granted burst SHALL never be abandoned.
REQ-014 On vs_fall in WAIT_DATA (missed end of frame), the block SHALL pulse frame_drop, then restart as in REQ-008 in the same bank.
REQ-015 In DONE, the block SHALL:
- pulse frame_done and set ready_bank = wr_bank;
- if ~wr_bank != rd_bank, set wr_bank <= ~wr_bank; otherwise keep wr_bank and pulse frame_drop;
- go to WAIT_SOF.
REQ-016 Data words beyond FRAME_WORDS SHALL never be requested; they are discarded by the fifo_clr pulse at the next vs_fall.
REQ-017 If enable=0, the FSM SHALL go to IDLE from WAIT_SOF or WAIT_DATA immediately, and from REQ or BURST only after wr_done.
REQ-018 The offset and remaining counters SHALL be 19 bits wide; address arithmetic SHALL be modulo 2^ADDR_W.
REQ-019 When vs_rise and wr_done occur in the same cycle, wr_done accounting SHALL happen first, then the vs_rise rule SHALL apply.

Reset
REQ-020 While rst_n=0, the state SHALL be IDLE and every output and counter SHALL be 0, asynchronously.
REQ-021 Reset asserted mid-burst SHALL drop wr_req in the same cycle, with no completion pulse afterwards.

Verification
REQ-022 The bench SHALL run with BURST_LEN=4 and FRAME_WORDS=10 and cover:
- Full frame, wr_bank=0, rd_bank=0, fifo_count=10 -> bursts (0,4), (4,4), (8,2) at base 0; frame_done=1; ready_bank=0; wr_bank becomes 1.
- Bank blocked, rd_bank=1 at DONE -> frame_done=1; frame_drop=1; wr_bank stays 0.
- Short frame, vs_rise after 4 words with fifo_count=3 -> extra burst (4,3); frame_drop=1; no swap.
- Arbiter stall, wr_ack held off 5 cycles -> wr_req, wr_addr and wr_len constant for 5 cycles.
- vs_rise during BURST together with wr_done -> final partial burst issued after the accounting of REQ-019.
- enable dropped mid-BURST -> wr_done accepted, then IDLE, busy=0; rst_n pulse mid-REQ -> all outputs 0.
